// File: rtl/ahb_slv_mux_dec.sv
// AHB-Lite address decoder, data-phase response mux and built-in default slave.
// Four mapped slaves; unmapped NONSEQ/SEQ transfers receive a two-cycle ERROR.
module ahb_slv_mux_dec #(
    parameter logic [31:0] p_BASE0 = 32'h0000_0000,
    parameter logic [31:0] p_MASK0 = 32'hFFFF_8000,
    parameter logic [31:0] p_BASE1 = 32'h2000_0000,
    parameter logic [31:0] p_MASK1 = 32'hFFFF_0000,
    parameter logic [31:0] p_BASE2 = 32'h4000_0000,
    parameter logic [31:0] p_MASK2 = 32'hFFFF_F000,
    parameter logic [31:0] p_BASE3 = 32'h4000_1000,
    parameter logic [31:0] p_MASK3 = 32'hFFFF_F000
) (
    input  logic         hclk,
    input  logic         hresetn,
    input  logic [31:0]  haddr,
    input  logic [1:0]   htrans,
    output logic [3:0]   hsel_s,
    input  logic [3:0]   hreadyout_s,
    input  logic [7:0]   hresp_s,
    input  logic [127:0] hrdata_s,
    output logic         hready,
    output logic [1:0]   hresp,
    output logic [31:0]  hrdata
);

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_ERR1 = 2'd1,
        D_ERR2 = 2'd2
    } dstate_t;

    localparam logic [2:0] SEL_DEF    = 3'd4;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    logic [2:0] dec_sel_s;
    logic [2:0] dsel_r;
    dstate_t    state_r;
    dstate_t    state_nxt_s;
    logic       err_req_s;
    logic       def_ready_s;
    logic [1:0] def_resp_s;
    logic       unused_s;

    assign unused_s = htrans[0];

    // Address decode, fixed priority with slave 0 highest
    always_comb begin
        dec_sel_s = SEL_DEF;
        hsel_s    = 4'b0000;
        if ((haddr & p_MASK0) == p_BASE0) begin
            dec_sel_s = 3'd0;
            hsel_s    = 4'b0001;
        end else if ((haddr & p_MASK1) == p_BASE1) begin
            dec_sel_s = 3'd1;
            hsel_s    = 4'b0010;
        end else if ((haddr & p_MASK2) == p_BASE2) begin
            dec_sel_s = 3'd2;
            hsel_s    = 4'b0100;
        end else if ((haddr & p_MASK3) == p_BASE3) begin
            dec_sel_s = 3'd3;
            hsel_s    = 4'b1000;
        end else begin
            dec_sel_s = SEL_DEF;
            hsel_s    = 4'b0000;
        end
    end

    // Data-phase select, advanced only when the bus is ready
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            dsel_r <= SEL_DEF;
        end else if (hready) begin
            dsel_r <= dec_sel_s;
        end else begin
            dsel_r <= dsel_r;
        end
    end

    assign err_req_s = hready & htrans[1] & (dec_sel_s == SEL_DEF);

    // Default-slave state register
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_r <= D_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Default-slave next state and response
    always_comb begin
        state_nxt_s = state_r;
        def_ready_s = 1'b1;
        def_resp_s  = RESP_OKAY;
        case (state_r)
            D_IDLE: begin
                if (err_req_s) begin
                    state_nxt_s = D_ERR1;
                end else begin
                    state_nxt_s = D_IDLE;
                end
            end
            D_ERR1: begin
                def_ready_s = 1'b0;
                def_resp_s  = RESP_ERROR;
                state_nxt_s = D_ERR2;
            end
            D_ERR2: begin
                def_resp_s = RESP_ERROR;
                if (err_req_s) begin
                    state_nxt_s = D_ERR1;
                end else begin
                    state_nxt_s = D_IDLE;
                end
            end
            default: begin
                state_nxt_s = D_IDLE;
            end
        endcase
    end

    // Response mux steered by the registered data-phase select
    always_comb begin
        hready = def_ready_s;
        hresp  = def_resp_s;
        hrdata = 32'h0000_0000;
        case (dsel_r)
            3'd0: begin
                hready = hreadyout_s[0];
                hresp  = hresp_s[1:0];
                hrdata = hrdata_s[31:0];
            end
            3'd1: begin
                hready = hreadyout_s[1];
                hresp  = hresp_s[3:2];
                hrdata = hrdata_s[63:32];
            end
            3'd2: begin
                hready = hreadyout_s[2];
                hresp  = hresp_s[5:4];
                hrdata = hrdata_s[95:64];
            end
            3'd3: begin
                hready = hreadyout_s[3];
                hresp  = hresp_s[7:6];
                hrdata = hrdata_s[127:96];
            end
            default: begin
                hready = def_ready_s;
                hresp  = def_resp_s;
                hrdata = 32'h0000_0000;
            end
        endcase
    end

endmodule
